// File: rtl/jtag_probe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtag_probe_pkg
// Purpose  : Shared definitions for the on-chip JTAG probe master: command
//            opcodes, FSM states and the TMS preamble/postamble patterns.
// Revision : 1.0 - initial release
// ============================================================================
package jtag_probe_pkg;

  // Instruction register length of the e203 debug TAP
  localparam int IR_LEN = 5;

  // Width of the TMS sequence index (preamble is at most 6 steps)
  localparam int SEQ_W = 3;

  // Command opcodes
  typedef enum logic [1:0] {
    OP_TAP_RESET = 2'd0,
    OP_IR_SCAN   = 2'd1,
    OP_DR_SCAN   = 2'd2,
    OP_IDLE_WAIT = 2'd3
  } op_e;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_POST  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  // TMS preambles, bit0 is driven in the first TCK cycle
  localparam logic [7:0] TMS_PRE_RESET = 8'b0001_1111;  // 1,1,1,1,1,0
  localparam logic [7:0] TMS_PRE_IR    = 8'b0000_0011;  // 1,1,0,0
  localparam logic [7:0] TMS_PRE_DR    = 8'b0000_0001;  // 1,0,0
  localparam logic [7:0] TMS_PRE_NONE  = 8'b0000_0000;

  // TMS postamble after the last shift bit: Update-xR, then Run-Test/Idle
  localparam logic [1:0] TMS_POST      = 2'b01;          // 1,0

  // Index of the last preamble step for an opcode
  function automatic logic [SEQ_W-1:0] pre_last(input op_e op);
    case (op)
      OP_TAP_RESET: pre_last = SEQ_W'(5);
      OP_IR_SCAN:   pre_last = SEQ_W'(3);
      OP_DR_SCAN:   pre_last = SEQ_W'(2);
      default:      pre_last = SEQ_W'(0);
    endcase
  endfunction

  // TMS preamble pattern for an opcode
  function automatic logic [7:0] pre_tms(input op_e op);
    case (op)
      OP_TAP_RESET: pre_tms = TMS_PRE_RESET;
      OP_IR_SCAN:   pre_tms = TMS_PRE_IR;
      OP_DR_SCAN:   pre_tms = TMS_PRE_DR;
      default:      pre_tms = TMS_PRE_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tck_gen.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tck_gen
// Purpose  : TCK divider. Each TCK cycle is CLK_DIV clocks low followed by
//            CLK_DIV clocks high. Runs only while enabled; idles low.
//            rise_stb : high in the first clock of the high phase (sample TDO)
//            fall_stb : high in the last clock of the high phase; TCK falls at
//                       the coming edge, so the sequencer steps here
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tck_gen
  import jtag_probe_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk_16M,
  input  logic reset_periph,
  input  logic en,
  output logic tck,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // Divider counter and phase toggle; held at the start of a low phase when idle
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // Divider state registers
  always_ff @(posedge clk_16M) begin
    if (reset_periph) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign tck      = phase_q;
  assign rise_stb = en & phase_q & (cnt_q == '0);
  assign fall_stb = en & phase_q & (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/jtag_probe_master.sv
`default_nettype none
// ============================================================================
// Module   : jtag_probe_master
// Purpose  : On-chip JTAG initiator. Runs TAP reset, IR/DR scans and idle
//            waits on request, returning one response per command with the
//            captured TDO bits.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_probe_master
  import jtag_probe_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic               clk_16M,
  input  logic               reset_periph,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [MAX_LEN-1:0] resp_data,
  output logic               busy,
  output logic               jtag_TCK,
  output logic               jtag_TMS,
  output logic               jtag_TDI,
  input  logic               jtag_TDO
);

  localparam int               BIT_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] resp_q, resp_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;

  logic [LEN_W-1:0]   len_eff;
  logic               last_bit;
  logic [7:0]         pre_vec;
  logic               tck;
  logic               fall_stb;
  logic               rise_stb;

  assign busy       = (state_q == ST_PRE) || (state_q == ST_SHIFT) ||
                      (state_q == ST_POST) || (state_q == ST_WAIT);
  assign cmd_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_data  = resp_q;
  assign jtag_TCK   = tck;
  assign jtag_TMS   = tms_q;
  assign jtag_TDI   = tdi_q;
  assign last_bit   = (LEN_W'(bit_q) == (len_q - LEN_W'(1)));

  jtag_tck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tck_gen (
    .clk_16M      (clk_16M),
    .reset_periph (reset_periph),
    .en           (busy),
    .tck          (tck),
    .fall_stb     (fall_stb),
    .rise_stb     (rise_stb)
  );

  // Requested length: zero runs one cycle, oversize requests clamp to MAX_LEN
  always_comb begin
    len_eff = cmd_len;
    if (cmd_len == '0) begin
      len_eff = LEN_W'(1);
    end else if (cmd_len > MAX_LEN_L) begin
      len_eff = MAX_LEN_L;
    end
  end

  // Sequencer next state; TMS/TDI are decoded from the next state so the
  // registered pins change exactly when TCK falls
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    data_d  = data_q;
    resp_d  = resp_q;
    seq_d   = seq_q;
    bit_d   = bit_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          len_d   = len_eff;
          data_d  = cmd_data;
          resp_d  = '0;
          seq_d   = '0;
          bit_d   = '0;
          state_d = (op_e'(cmd_op) == OP_IDLE_WAIT) ? ST_WAIT : ST_PRE;
        end
      end
      ST_PRE: begin
        if (fall_stb) begin
          if (seq_q == pre_last(op_q)) begin
            seq_d   = '0;
            state_d = (op_q == OP_TAP_RESET) ? ST_RESP : ST_SHIFT;
          end else begin
            seq_d   = seq_q + SEQ_W'(1);
          end
        end
      end
      ST_SHIFT: begin
        if (rise_stb) begin
          resp_d[bit_q] = jtag_TDO;
        end
        if (fall_stb) begin
          if (last_bit) begin
            seq_d   = '0;
            state_d = ST_POST;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end
      ST_POST: begin
        if (fall_stb) begin
          if (seq_q == SEQ_W'(1)) begin
            seq_d   = '0;
            state_d = ST_RESP;
          end else begin
            seq_d   = seq_q + SEQ_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (fall_stb) begin
          if (last_bit) begin
            state_d = ST_RESP;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    pre_vec = pre_tms(op_d);
    tms_d   = 1'b1;
    tdi_d   = 1'b0;
    case (state_d)
      ST_PRE: begin
        tms_d = pre_vec[seq_d];
      end
      ST_SHIFT: begin
        tms_d = (LEN_W'(bit_d) == (len_d - LEN_W'(1)));
        tdi_d = data_d[bit_d];
      end
      ST_POST: begin
        tms_d = TMS_POST[seq_d[0]];
      end
      ST_WAIT: begin
        tms_d = 1'b0;
      end
      default: begin
        tms_d = 1'b1;
      end
    endcase
  end

  // Sequencer registers; reset aborts any operation immediately
  always_ff @(posedge clk_16M) begin
    if (reset_periph) begin
      state_q <= ST_IDLE;
      op_q    <= OP_TAP_RESET;
      len_q   <= '0;
      data_q  <= '0;
      resp_q  <= '0;
      seq_q   <= '0;
      bit_q   <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
      seq_q   <= seq_d;
      bit_q   <= bit_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtag_probe_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_probe_master
// Purpose  : Directed self-checking bench for jtag_probe_master driving a
//            behavioural e203 TAP model (IR length 5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_probe_master;

  localparam int          CLK_DIV = 4;
  localparam int          MAX_LEN = 64;
  localparam int          LEN_W   = 7;
  localparam logic [31:0] IDCODE  = 32'h1E20_0A6D;

  logic               clk_16M = 1'b0;
  logic               reset_periph = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'd0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               resp_valid;
  logic               resp_ready = 1'b0;
  logic [MAX_LEN-1:0] resp_data;
  logic               busy;
  logic               jtag_TCK;
  logic               jtag_TMS;
  logic               jtag_TDI;
  logic               jtag_TDO;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int tck_total    = 0;
  logic tms_hist [0:4095];

  jtag_probe_master #(
    .CLK_DIV (CLK_DIV),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) dut (
    .clk_16M      (clk_16M),
    .reset_periph (reset_periph),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_len      (cmd_len),
    .cmd_data     (cmd_data),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .busy         (busy),
    .jtag_TCK     (jtag_TCK),
    .jtag_TMS     (jtag_TMS),
    .jtag_TDI     (jtag_TDI),
    .jtag_TDO     (jtag_TDO)
  );

  always #31 clk_16M = ~clk_16M;

  always @(posedge clk_16M) cyc <= cyc + 1;

  // TMS log, one entry per TCK rising edge
  always @(posedge jtag_TCK) begin
    if (tck_total < 4096) tms_hist[tck_total] = jtag_TMS;
    tck_total = tck_total + 1;
  end

  // ---------------- behavioural e203 TAP ----------------
  typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
  tap_t        tap_st = TLR;
  logic [4:0]  tap_ir = 5'h01;
  logic [4:0]  tap_irsr = 5'h00;
  logic [31:0] tap_dr = 32'h0;
  logic        tap_tdo = 1'b0;

  assign jtag_TDO = tap_tdo;

  always @(posedge jtag_TCK) begin
    case (tap_st)
      TLR:   tap_ir <= 5'h01;
      CAPDR: tap_dr <= (tap_ir == 5'h01) ? IDCODE : 32'h0;
      SHDR:  if (tap_ir == 5'h01) tap_dr <= {jtag_TDI, tap_dr[31:1]};
             else tap_dr <= {31'h0, jtag_TDI};
      CAPIR: tap_irsr <= 5'b00001;
      SHIR:  tap_irsr <= {jtag_TDI, tap_irsr[4:1]};
      UPIR:  tap_ir <= tap_irsr;
      default: ;
    endcase
    case (tap_st)
      TLR:   tap_st <= jtag_TMS ? TLR   : RTI;
      RTI:   tap_st <= jtag_TMS ? SELDR : RTI;
      SELDR: tap_st <= jtag_TMS ? SELIR : CAPDR;
      CAPDR: tap_st <= jtag_TMS ? EX1DR : SHDR;
      SHDR:  tap_st <= jtag_TMS ? EX1DR : SHDR;
      EX1DR: tap_st <= jtag_TMS ? UPDR  : PADR;
      PADR:  tap_st <= jtag_TMS ? EX2DR : PADR;
      EX2DR: tap_st <= jtag_TMS ? UPDR  : SHDR;
      UPDR:  tap_st <= jtag_TMS ? SELDR : RTI;
      SELIR: tap_st <= jtag_TMS ? TLR   : CAPIR;
      CAPIR: tap_st <= jtag_TMS ? EX1IR : SHIR;
      SHIR:  tap_st <= jtag_TMS ? EX1IR : SHIR;
      EX1IR: tap_st <= jtag_TMS ? UPIR  : PAIR;
      PAIR:  tap_st <= jtag_TMS ? EX2IR : PAIR;
      EX2IR: tap_st <= jtag_TMS ? UPIR  : SHIR;
      UPIR:  tap_st <= jtag_TMS ? SELDR : RTI;
      default: tap_st <= TLR;
    endcase
  end

  always @(negedge jtag_TCK) begin
    if (tap_st == SHDR)      tap_tdo <= tap_dr[0];
    else if (tap_st == SHIR) tap_tdo <= tap_irsr[0];
    else                     tap_tdo <= 1'b0;
  end

  // ---------------- command helpers ----------------
  task automatic send_cmd(input logic [1:0] op, input int len, input logic [63:0] data,
                          output int acc_cyc, output int tck_start);
    bit ok;
    @(negedge clk_16M);
    tck_start = tck_total;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    cmd_data  = data;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk_16M);
    end
    acc_cyc = cyc;
    @(negedge clk_16M);
    cmd_valid = 1'b0;
    if (!ok) begin
      tests_run++; tests_failed++;
      $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic wait_resp(input int acc_cyc, output int lat, output logic [63:0] d);
    for (int i = 0; i < 5000; i++) begin
      if (resp_valid) break;
      @(negedge clk_16M);
    end
    if (!resp_valid) begin
      tests_run++; tests_failed++;
      $display("FAIL resp_timeout: resp_valid=%b required 1", resp_valid);
      lat = -1;
    end else begin
      lat = cyc - acc_cyc;
    end
    d = resp_data;
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(negedge clk_16M);
    resp_ready = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input int len, input logic [63:0] data,
                        output int lat, output logic [63:0] d, output int ntck, output int ts);
    int acc;
    send_cmd(op, len, data, acc, ts);
    wait_resp(acc, lat, d);
    ntck = tck_total - ts;
    consume();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk_16M);
    reset_periph = 1'b0;
    @(negedge clk_16M);
    tests_run++;
    if ({jtag_TCK, jtag_TMS, jtag_TDI} !== 3'b010) begin
      tests_failed++;
      $display("FAIL reset_pins: TCK/TMS/TDI=%b required 010", {jtag_TCK, jtag_TMS, jtag_TDI});
    end
    tests_run++;
    if ({cmd_ready, resp_valid, busy} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_handshake: ready/valid/busy=%b required 100", {cmd_ready, resp_valid, busy});
    end
    tests_run++;
    if (resp_data !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_resp_data: got %h required 0", resp_data);
    end
  endtask

  task automatic test_tap_reset();
    int lat, ntck, ts;
    logic [63:0] d;
    logic [5:0] pat;
    run_op(2'd0, 0, 64'h0, lat, d, ntck, ts);
    for (int k = 0; k < 6; k++) pat[k] = tms_hist[ts + k];
    tests_run++;
    if (lat !== 49) begin
      tests_failed++; $display("FAIL tap_reset_latency: got %0d required 49", lat);
    end
    tests_run++;
    if (ntck !== 6 || pat !== 6'b011111) begin
      tests_failed++;
      $display("FAIL tap_reset_tms: ncyc=%0d pattern(bit0 first)=%b required 6 / 011111", ntck, pat);
    end
    tests_run++;
    if (d !== 64'h0 || tap_st != RTI) begin
      tests_failed++;
      $display("FAIL tap_reset_result: data=%h tap_state=%0d required 0 / RTI", d, tap_st);
    end
  endtask

  task automatic test_idcode();
    int lat, ntck, ts;
    logic [63:0] d;
    run_op(2'd2, 32, 64'h0, lat, d, ntck, ts);
    tests_run++;
    if (d !== {32'h0, IDCODE}) begin
      tests_failed++; $display("FAIL idcode_data: got %h required %h", d, {32'h0, IDCODE});
    end
    tests_run++;
    if (lat !== 297) begin
      tests_failed++; $display("FAIL idcode_latency: got %0d required 297", lat);
    end
  endtask

  task automatic test_bypass();
    int lat, ntck, ts;
    logic [63:0] d;
    run_op(2'd1, 5, 64'h1F, lat, d, ntck, ts);
    tests_run++;
    if (d !== 64'h01 || lat !== 89) begin
      tests_failed++; $display("FAIL ir_scan: data=%h lat=%0d required 01 / 89", d, lat);
    end
    run_op(2'd2, 8, 64'hA5, lat, d, ntck, ts);
    tests_run++;
    if (d !== 64'h4A || lat !== 105) begin
      tests_failed++; $display("FAIL bypass_dr: data=%h lat=%0d required 4a / 105", d, lat);
    end
  endtask

  task automatic test_back_to_back();
    int acc, ts, lat;
    logic [63:0] d;
    bit bad;
    send_cmd(2'd2, 8, 64'h3C, acc, ts);
    wait_resp(acc, lat, d);
    tests_run++;
    if (d !== 64'h78) begin
      tests_failed++; $display("FAIL hold_dr_data: got %h required 78", d);
    end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_16M);
      if (resp_data !== d || cmd_ready !== 1'b0 || jtag_TCK !== 1'b0 || resp_valid !== 1'b1) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL hold_stable: data=%h ready=%b tck=%b valid=%b required %h 0 0 1",
               resp_data, cmd_ready, jtag_TCK, resp_valid, d);
    end
    // consume and new command in the same cycle
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_len = LEN_W'(1); cmd_data = '0;
    resp_ready = 1'b1;
    tests_run++;
    if (cmd_ready !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_ready_low: got %b required 0", cmd_ready);
    end
    @(negedge clk_16M);
    resp_ready = 1'b0;
    tests_run++;
    if (cmd_ready !== 1'b1 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_ready_next: ready=%b valid=%b required 1 0", cmd_ready, resp_valid);
    end
    acc = cyc;
    @(negedge clk_16M);
    cmd_valid = 1'b0;
    wait_resp(acc, lat, d);
    tests_run++;
    if (lat !== 9 || d !== 64'h0) begin
      tests_failed++; $display("FAIL b2b_wait: lat=%0d data=%h required 9 / 0", lat, d);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int acc, ts;
    bit seen;
    send_cmd(2'd2, 32, 64'h0, acc, ts);
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (tck_total - ts >= 14) begin seen = 1'b1; break; end
      @(negedge clk_16M);
    end
    if (!seen) begin
      tests_run++; tests_failed++;
      $display("FAIL mid_reset_reach: tck=%0d required 14", tck_total - ts);
    end
    reset_periph = 1'b1;
    @(negedge clk_16M);
    tests_run++;
    if ({jtag_TCK, jtag_TMS, busy, resp_valid} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL mid_reset_state: tck/tms/busy/valid=%b required 0100",
               {jtag_TCK, jtag_TMS, busy, resp_valid});
    end
    reset_periph = 1'b0;
    @(negedge clk_16M);
    test_tap_reset();
    test_idcode();
  endtask

  task automatic test_idle_wait();
    int lat, ntck, ts;
    logic [63:0] d;
    run_op(2'd3, 0, 64'hFFFF, lat, d, ntck, ts);
    tests_run++;
    if (ntck !== 1 || tms_hist[ts] !== 1'b0 || lat !== 9 || d !== 64'h0) begin
      tests_failed++;
      $display("FAIL idle_wait_len0: ncyc=%0d tms=%b lat=%0d data=%h required 1 0 9 0",
               ntck, tms_hist[ts], lat, d);
    end
  endtask

  task automatic test_clamp();
    int lat, ntck, ts;
    logic [63:0] d;
    run_op(2'd2, 100, 64'h0123_4567_89AB_CDEF, lat, d, ntck, ts);
    tests_run++;
    if (ntck !== 69 || lat !== 553) begin
      tests_failed++; $display("FAIL clamp_cycles: ncyc=%0d lat=%0d required 69 / 553", ntck, lat);
    end
    tests_run++;
    if (d !== {32'h89AB_CDEF, IDCODE}) begin
      tests_failed++; $display("FAIL clamp_data: got %h required %h", d, {32'h89AB_CDEF, IDCODE});
    end
  endtask

  initial begin
    test_reset();
    test_tap_reset();
    test_idcode();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    test_idle_wait();
    test_clamp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
